// File: rtl/fantasticfft_pkg.sv
// Shared types and helpers for the FFT twiddle complex multiplier.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package fantasticfft_pkg;

  typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} cmul_state_t;

  // Order in which the four real partial products go through the multiplier.
  localparam logic [1:0] P_RR = 2'd0;  // a_re * w_re
  localparam logic [1:0] P_II = 2'd1;  // a_im * w_im
  localparam logic [1:0] P_RI = 2'd2;  // a_re * w_im
  localparam logic [1:0] P_IR = 2'd3;  // a_im * w_re

  // Convert a Q1.(width-1)-scaled sum back to integer scale:
  // round half-up, arithmetic shift, then clamp to the signed width range.
  function automatic logic signed [31:0] sat_round(input logic signed [63:0] sum,
                                                   input int width);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (sum + (64'sd1 <<< (width - 2))) >>> (width - 1);
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/fft_shift_add_mult.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles; bit 0 is consumed on the load edge, valid pulses after the WIDTH-th edge.
// Backpressure: none; a new load restarts it, prod holds until the next load.
module fft_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 valid
);
  localparam int BW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [BW-1:0]      cnt;
  logic               run;

  // Accumulate the shifted multiplicand for each set multiplier bit, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      mc    <= '0;
      mp    <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        prod <= mplier[0] ? {{WIDTH{1'b0}}, mcand} : '0;
        mc   <= {{(WIDTH-1){1'b0}}, mcand, 1'b0};
        mp   <= mplier >> 1;
        cnt  <= BW'(1);
        run  <= 1'b1;
      end else if (run) begin
        if (mp[0]) begin
          prod <= prod + mc;
        end
        mc  <= mc << 1;
        mp  <= mp >> 1;
        cnt <= cnt + BW'(1);
        if (cnt == BW'(WIDTH - 1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fft_twiddle_cmul.sv
// Sequential complex multiply y = a * w with a Q1.(WIDTH-1) twiddle, one shared real multiplier.
// Latency: done after 4*WIDTH+1 edges from the accepting edge; back-to-back period 4*WIDTH+3.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module fft_twiddle_cmul
  import fantasticfft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        a_re,
  input  logic [WIDTH-1:0]        a_im,
  input  logic [WIDTH-1:0]        w_re,
  input  logic [WIDTH-1:0]        w_im,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im
);
  localparam int BW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH + 1;

  cmul_state_t state, state_nxt;

  logic [WIDTH-1:0]    ar_q, ai_q, wr_q, wi_q;
  logic [1:0]          p;
  logic [1:0]          p_done;
  logic [BW-1:0]       b;
  logic                last_bit;
  logic                load;
  logic                neg;
  logic [WIDTH-1:0]    mcand, mplier;
  logic [2*WIDTH-1:0]  prod;
  logic                valid;
  logic signed [PW-1:0] sprod, re_acc, im_acc, re_nxt, im_nxt;

  // Magnitude as an unsigned WIDTH-bit value; the most negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign last_bit = (b == BW'(WIDTH - 1));
  assign load     = (state == MUL) && (b == '0);
  assign p_done   = p - 2'd1;   // product the multiplier has just finished
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Route the magnitudes of the operand pair for the current product index.
  always_comb begin
    mcand  = mag(ar_q);
    mplier = mag(wr_q);
    case (p)
      P_RR: begin mcand = mag(ar_q); mplier = mag(wr_q); end
      P_II: begin mcand = mag(ai_q); mplier = mag(wi_q); end
      P_RI: begin mcand = mag(ar_q); mplier = mag(wi_q); end
      P_IR: begin mcand = mag(ai_q); mplier = mag(wr_q); end
      default: ;
    endcase
  end

  // Re-apply the sign to the finished product and fold it into re or im.
  always_comb begin
    neg = 1'b0;
    case (p_done)
      P_RR:    neg = ar_q[WIDTH-1] ^ wr_q[WIDTH-1];
      P_II:    neg = ai_q[WIDTH-1] ^ wi_q[WIDTH-1];
      P_RI:    neg = ar_q[WIDTH-1] ^ wi_q[WIDTH-1];
      P_IR:    neg = ai_q[WIDTH-1] ^ wr_q[WIDTH-1];
      default: ;
    endcase
    sprod  = neg ? -$signed({1'b0, prod}) : $signed({1'b0, prod});
    re_nxt = re_acc;
    im_nxt = im_acc;
    if (valid) begin
      case (p_done)
        P_RR:    re_nxt = re_acc + sprod;
        P_II:    re_nxt = re_acc - sprod;
        default: im_nxt = im_acc + sprod;
      endcase
    end
  end

  fft_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .mcand  (mcand),
    .mplier (mplier),
    .prod   (prod),
    .valid  (valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: MUL runs exactly 4*WIDTH cycles, SUM and DONE one cycle each.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (last_bit && (p == P_IR)) state_nxt = SUM;
      SUM:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, product/bit sequencing, accumulation and final rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q   <= '0;
      ai_q   <= '0;
      wr_q   <= '0;
      wi_q   <= '0;
      p      <= '0;
      b      <= '0;
      re_acc <= '0;
      im_acc <= '0;
      y_re   <= '0;
      y_im   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ar_q   <= a_re;
            ai_q   <= a_im;
            wr_q   <= w_re;
            wi_q   <= w_im;
            p      <= '0;
            b      <= '0;
            re_acc <= '0;
            im_acc <= '0;
          end
        end
        MUL: begin
          if (last_bit) begin
            b <= '0;
            p <= p + 2'd1;
          end else begin
            b <= b + BW'(1);
          end
          re_acc <= re_nxt;
          im_acc <= im_nxt;
        end
        SUM: begin
          // The last product lands this cycle, so use the folded-in next values.
          re_acc <= re_nxt;
          im_acc <= im_nxt;
          y_re   <= WIDTH'(sat_round(64'(re_nxt), WIDTH));
          y_im   <= WIDTH'(sat_round(64'(im_nxt), WIDTH));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_cmul.sv
// Directed-vector bench for fft_twiddle_cmul (WIDTH=8).
// Latency: checks done timing relative to the accepting edge.
// Backpressure: checks that start outside IDLE is ignored.
module tb_fft_twiddle_cmul;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        a_re = '0, a_im = '0, w_re = '0, w_im = '0;
  logic              busy, done;
  logic signed [7:0] y_re, y_im;

  int n_checks = 0;
  int n_fail = 0;

  fft_twiddle_cmul #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_re  (a_re),
    .a_im  (a_im),
    .w_re  (w_re),
    .w_im  (w_im),
    .busy  (busy),
    .done  (done),
    .y_re  (y_re),
    .y_im  (y_im)
  );

  always #5 clk = ~clk;

  // Launch one operation, scramble inputs after capture, watch 45 edges for done.
  task automatic do_op(input int ar, input int ai, input int wr, input int wi,
                       output int done_edge, output int npulse);
    @(negedge clk);
    a_re = 8'(ar); a_im = 8'(ai); w_re = 8'(wr); w_im = 8'(wi);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_re = ~a_re; a_im = ~a_im; w_re = 8'h11; w_im = 8'h99;
    done_edge = -1;
    npulse = 0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        npulse++;
        if (done_edge < 0) done_edge = e;
      end
    end
  endtask

  task automatic test_reset();
    int de, np;
    #23;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (y_re !== 8'sd0) begin n_fail++; $display("FAIL reset_y_re: got %0d want 0", y_re); end
    n_checks++; if (y_im !== 8'sd0) begin n_fail++; $display("FAIL reset_y_im: got %0d want 0", y_im); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(100, -50, 'h40, 0, de, np);
    n_checks++; if ($signed(y_re) !== 50) begin n_fail++; $display("FAIL first_y_re: got %0d want 50", y_re); end
    n_checks++; if ($signed(y_im) !== -25) begin n_fail++; $display("FAIL first_y_im: got %0d want -25", y_im); end
    // Mid-operation reset at cycle 10.
    @(negedge clk);
    a_re = 8'd5; a_im = 8'd5; w_re = 8'h40; w_im = 8'h40; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done); end
    n_checks++; if (y_re !== 8'sd0) begin n_fail++; $display("FAIL midreset_y_re: got %0d want 0", y_re); end
    n_checks++; if (y_im !== 8'sd0) begin n_fail++; $display("FAIL midreset_y_im: got %0d want 0", y_im); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(100, -50, 'h40, 0, de, np);
    n_checks++; if ($signed(y_re) !== 50) begin n_fail++; $display("FAIL post_reset_y_re: got %0d want 50", y_re); end
    n_checks++; if ($signed(y_im) !== -25) begin n_fail++; $display("FAIL post_reset_y_im: got %0d want -25", y_im); end
    n_checks++; if (de !== 33) begin n_fail++; $display("FAIL latency: done at edge %0d want 33", de); end
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", np); end
  endtask

  task automatic test_imag_twiddle();
    int de, np;
    do_op(64, 0, 'h00, 'h7F, de, np);
    n_checks++; if ($signed(y_re) !== 0) begin n_fail++; $display("FAIL imag_y_re: got %0d want 0", y_re); end
    n_checks++; if ($signed(y_im) !== 64) begin n_fail++; $display("FAIL imag_y_im: got %0d want 64", y_im); end
  endtask

  task automatic test_saturation();
    int de, np;
    do_op(-128, 0, 'h80, 'h00, de, np);
    n_checks++; if ($signed(y_re) !== 127) begin n_fail++; $display("FAIL sat1_y_re: got %0d want 127", y_re); end
    n_checks++; if ($signed(y_im) !== 0) begin n_fail++; $display("FAIL sat1_y_im: got %0d want 0", y_im); end
    do_op(-128, -128, 'h80, 'h80, de, np);
    n_checks++; if ($signed(y_re) !== 0) begin n_fail++; $display("FAIL sat2_y_re: got %0d want 0", y_re); end
    n_checks++; if ($signed(y_im) !== 127) begin n_fail++; $display("FAIL sat2_y_im: got %0d want 127", y_im); end
  endtask

  task automatic test_rounding();
    int de, np;
    do_op(-3, 0, 'h40, 0, de, np);
    n_checks++; if ($signed(y_re) !== -1) begin n_fail++; $display("FAIL round_neg_y_re: got %0d want -1", y_re); end
    n_checks++; if ($signed(y_im) !== 0) begin n_fail++; $display("FAIL round_neg_y_im: got %0d want 0", y_im); end
    do_op(3, 0, 'h40, 0, de, np);
    n_checks++; if ($signed(y_re) !== 2) begin n_fail++; $display("FAIL round_pos_y_re: got %0d want 2", y_re); end
    n_checks++; if ($signed(y_im) !== 0) begin n_fail++; $display("FAIL round_pos_y_im: got %0d want 0", y_im); end
  endtask

  // a=(10,20), w=(0.5,0.5): re=-640 -> -5, im=1920 -> 15. Extra starts at 5 and 33 must be dropped.
  task automatic test_ignored_start();
    int de = -1;
    int np = 0;
    @(negedge clk);
    a_re = 8'd10; a_im = 8'd20; w_re = 8'h40; w_im = 8'h40; start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 75; e++) begin
      @(negedge clk);
      start = (e == 5) || (e == 33);
      a_re = 8'(e + 40); a_im = 8'(3 * e); w_re = 8'h7F; w_im = 8'h20;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        np++;
        if (de < 0) de = e;
      end
    end
    start = 1'b0;
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", np); end
    n_checks++; if (de !== 33) begin n_fail++; $display("FAIL ignore_done_edge: got %0d want 33", de); end
    n_checks++; if ($signed(y_re) !== -5) begin n_fail++; $display("FAIL ignore_y_re: got %0d want -5", y_re); end
    n_checks++; if ($signed(y_im) !== 15) begin n_fail++; $display("FAIL ignore_y_im: got %0d want 15", y_im); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b want 0", busy); end
  endtask

  // start held high, a=(e+10, 5-e) at edge e, w=(0.5,0.25): accepts at 0, 35, 70.
  task automatic test_back_to_back();
    int exp_edge[3] = '{33, 68, 103};
    int exp_re[3]   = '{4, 30, 56};
    int exp_im[3]   = '{5, -4, -12};
    int got_edge[3] = '{-1, -1, -1};
    int got_re[3]   = '{-999, -999, -999};
    int got_im[3]   = '{-999, -999, -999};
    int k = 0;
    for (int e = 0; e <= 110; e++) begin
      @(negedge clk);
      start = 1'b1;
      a_re = 8'(e + 10); a_im = 8'(5 - e); w_re = 8'h40; w_im = 8'h20;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (k < 3) begin
          got_edge[k] = e;
          got_re[k]   = int'($signed(y_re));
          got_im[k]   = int'($signed(y_im));
        end
        k++;
      end
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", k); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (got_edge[i] !== exp_edge[i]) begin n_fail++; $display("FAIL b2b_edge[%0d]: got %0d want %0d", i, got_edge[i], exp_edge[i]); end
      n_checks++; if (got_re[i] !== exp_re[i]) begin n_fail++; $display("FAIL b2b_y_re[%0d]: got %0d want %0d", i, got_re[i], exp_re[i]); end
      n_checks++; if (got_im[i] !== exp_im[i]) begin n_fail++; $display("FAIL b2b_y_im[%0d]: got %0d want %0d", i, got_im[i], exp_im[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_imag_twiddle();
    test_saturation();
    test_rounding();
    test_ignored_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
